// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the PC fetch sequencer.
package pc_fetch_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DefaultResetVector = 32'h0000_0000;
  localparam logic [XLEN-1:0] DefaultTrapVector  = 32'h0000_0100;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StExec,
    StHalted
  } fetch_state_e;

  function automatic logic is_misaligned(logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/response handshake between fetch sequencer and memory.
interface pc_fetch_ctrl_if;

  logic                                 imem_req_valid;
  logic                                 imem_req_ready;
  logic [pc_fetch_ctrl_pkg::XLEN-1:0]   imem_addr;
  logic                                 imem_rsp_valid;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid
  );

endinterface

// File: rtl/pc_fetch_ctrl_pc_next_sel.sv
// Next-PC priority mux (trap > jump > branch > sequential) with target alignment check.
module pc_fetch_ctrl_pc_next_sel
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] TrapVector = DefaultTrapVector
) (
  input  logic            trap_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misalign_o
);

  always_comb begin
    next_pc_o  = pc_plus4_i;
    misalign_o = 1'b0;
    if (trap_i) begin
      // A requested trap is not itself a misaligned-target event.
      next_pc_o = TrapVector;
    end else if (jump_i) begin
      misalign_o = is_misaligned(jump_target_i);
      next_pc_o  = misalign_o ? TrapVector : jump_target_i;
    end else if (branch_taken_i) begin
      misalign_o = is_misaligned(branch_target_i);
      next_pc_o  = misalign_o ? TrapVector : branch_target_i;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and IDLE/REQ/WAIT/EXEC/HALTED fetch sequencer; PC+4 adder is external.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DefaultResetVector,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = DefaultTrapVector
) (
  input  logic                    clk,
  input  logic                    reset,
  pc_fetch_ctrl_if.master         imem,
  output logic [XLEN-1:0]         pc_out,
  input  logic [XLEN-1:0]         pc_plus4_in,
  output logic                    instr_valid,
  input  logic                    branch_taken,
  input  logic [XLEN-1:0]         branch_target,
  input  logic                    jump,
  input  logic [XLEN-1:0]         jump_target,
  input  logic                    trap,
  input  logic                    halt,
  output logic                    misalign_trap,
  output logic                    halted
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] sel_pc;
  logic            sel_misalign;

  pc_fetch_ctrl_pc_next_sel #(
    .TrapVector(TRAP_VECTOR)
  ) u_pc_next_sel (
    .trap_i         (trap),
    .jump_i         (jump),
    .jump_target_i  (jump_target),
    .branch_taken_i (branch_taken),
    .branch_target_i(branch_target),
    .pc_plus4_i     (pc_plus4_in),
    .next_pc_o      (sel_pc),
    .misalign_o     (sel_misalign)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq:  if (imem.imem_req_ready) state_d = StWait;
      StWait: if (imem.imem_rsp_valid) state_d = StExec;
      StExec: begin
        pc_d       = sel_pc;
        misalign_d = sel_misalign;
        state_d    = halt ? StHalted : StReq;
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_out              = pc_q;
  assign imem.imem_addr      = pc_q;
  assign imem.imem_req_valid = (state_q == StReq);
  assign instr_valid         = (state_q == StExec);
  assign misalign_trap       = misalign_q;
  assign halted              = (state_q == StHalted);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl.
module tb_pc_fetch_ctrl;
  import pc_fetch_ctrl_pkg::*;

  logic            clk;
  logic            reset;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus4_in;
  logic            instr_valid;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            jump;
  logic [XLEN-1:0] jump_target;
  logic            trap;
  logic            halt;
  logic            misalign_trap;
  logic            halted;

  int checks = 0;
  int errors = 0;

  pc_fetch_ctrl_if imem_if ();

  pc_fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .imem         (imem_if),
    .pc_out       (pc_out),
    .pc_plus4_in  (pc_plus4_in),
    .instr_valid  (instr_valid),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .trap         (trap),
    .halt         (halt),
    .misalign_trap(misalign_trap),
    .halted       (halted)
  );

  // External PC+4 adder.
  assign pc_plus4_in = pc_out + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From REQ: accept request, respond next cycle; returns in EXEC.
  task automatic go_exec();
    imem_if.imem_req_ready = 1'b1;
    step();
    imem_if.imem_req_ready = 1'b0;
    imem_if.imem_rsp_valid = 1'b1;
    step();
    imem_if.imem_rsp_valid = 1'b0;
  endtask

  task automatic clear_redirects();
    branch_taken = 1'b0;
    jump         = 1'b0;
    trap         = 1'b0;
    halt         = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if (pc_out !== 32'h0) begin
      errors++; $display("FAIL reset_pc: got %h expected %h", pc_out, 32'h0);
    end
    checks++;
    if (imem_if.imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0
        || misalign_trap !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b iv=%b halted=%b mis=%b expected 0000",
               imem_if.imem_req_valid, instr_valid, halted, misalign_trap);
    end
    reset = 1'b0;
    checks++;
    if (imem_if.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL idle_no_req: got %b expected 0", imem_if.imem_req_valid);
    end
    step();
    checks++;
    if (imem_if.imem_req_valid !== 1'b1 || imem_if.imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_req: got valid=%b addr=%h expected valid=1 addr=0",
               imem_if.imem_req_valid, imem_if.imem_addr);
    end
  endtask

  task automatic test_ready_delay();
    int bad = 0;
    imem_if.imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (imem_if.imem_req_valid !== 1'b1 || imem_if.imem_addr !== 32'h0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL req_held_stable: got %0d bad cycles expected 0", bad);
    end
    imem_if.imem_req_ready = 1'b1;
    step();
    imem_if.imem_req_ready = 1'b0;
    checks++;
    if (imem_if.imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL wait_state: got req=%b iv=%b expected 0 0",
               imem_if.imem_req_valid, instr_valid);
    end
    step();
    checks++;
    if (instr_valid !== 1'b0 || pc_out !== 32'h0) begin
      errors++; $display("FAIL wait_hold: got iv=%b pc=%h expected 0 0", instr_valid, pc_out);
    end
    imem_if.imem_rsp_valid = 1'b1;
    step();
    imem_if.imem_rsp_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h0) begin
      errors++; $display("FAIL exec_pulse: got iv=%b pc=%h expected 1 0", instr_valid, pc_out);
    end
    step();
    checks++;
    if (instr_valid !== 1'b0 || pc_out !== 32'h4 || imem_if.imem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL seq_next: got iv=%b pc=%h req=%b expected 0 4 1",
               instr_valid, pc_out, imem_if.imem_req_valid);
    end
  endtask

  task automatic test_priority();
    go_exec();
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++; $display("FAIL prio_exec: got iv=%b expected 1", instr_valid);
    end
    branch_taken = 1'b1; branch_target = 32'h40;
    jump = 1'b1;         jump_target   = 32'h80;
    step();
    clear_redirects();
    checks++;
    if (pc_out !== 32'h80 || misalign_trap !== 1'b0) begin
      errors++;
      $display("FAIL jump_over_branch: got pc=%h mis=%b expected 80 0", pc_out, misalign_trap);
    end
    go_exec();
    branch_taken = 1'b1; branch_target = 32'h40;
    jump = 1'b1;         jump_target   = 32'h80;
    trap = 1'b1;
    step();
    clear_redirects();
    checks++;
    if (pc_out !== 32'h100 || misalign_trap !== 1'b0) begin
      errors++;
      $display("FAIL trap_priority: got pc=%h mis=%b expected 100 0", pc_out, misalign_trap);
    end
  endtask

  task automatic test_misalign();
    go_exec();
    branch_taken = 1'b1; branch_target = 32'h42;
    step();
    clear_redirects();
    checks++;
    if (pc_out !== 32'h100 || misalign_trap !== 1'b1 || imem_if.imem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL misalign_branch: got pc=%h mis=%b req=%b expected 100 1 1",
               pc_out, misalign_trap, imem_if.imem_req_valid);
    end
    step();
    checks++;
    if (misalign_trap !== 1'b0) begin
      errors++; $display("FAIL misalign_pulse_width: got %b expected 0", misalign_trap);
    end
  endtask

  task automatic test_halt();
    int bad = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    go_exec();
    step();
    go_exec();
    step();
    checks++;
    if (pc_out !== 32'h8) begin
      errors++; $display("FAIL halt_setup_pc: got %h expected 8", pc_out);
    end
    go_exec();
    halt = 1'b1;
    step();
    halt = 1'b0;
    checks++;
    if (pc_out !== 32'hC || halted !== 1'b1) begin
      errors++; $display("FAIL halt_entry: got pc=%h halted=%b expected c 1", pc_out, halted);
    end
    for (int i = 0; i < 20; i++) begin
      imem_if.imem_req_ready = 1'b1;
      imem_if.imem_rsp_valid = i[0];
      step();
      if (imem_if.imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b1
          || pc_out !== 32'hC) bad++;
    end
    imem_if.imem_req_ready = 1'b0;
    imem_if.imem_rsp_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL halted_quiet: got %0d bad cycles expected 0", bad);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (pc_out !== 32'h0 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_recover: got pc=%h halted=%b expected 0 0", pc_out, halted);
    end
  endtask

  task automatic test_reset_in_wait();
    step();
    go_exec();
    step();
    // Now at pc=4 in REQ; move into WAIT then reset with a response pending.
    imem_if.imem_req_ready = 1'b1;
    step();
    imem_if.imem_req_ready = 1'b0;
    checks++;
    if (imem_if.imem_req_valid !== 1'b0 || pc_out !== 32'h4) begin
      errors++;
      $display("FAIL rst_wait_setup: got req=%b pc=%h expected 0 4",
               imem_if.imem_req_valid, pc_out);
    end
    reset = 1'b1;
    imem_if.imem_rsp_valid = 1'b1;
    step();
    checks++;
    if (instr_valid !== 1'b0 || pc_out !== 32'h0) begin
      errors++; $display("FAIL rst_in_wait: got iv=%b pc=%h expected 0 0", instr_valid, pc_out);
    end
    reset = 1'b0;
    step();
    checks++;
    if (instr_valid !== 1'b0 || imem_if.imem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_in_idle: got iv=%b req=%b expected 0 1",
               instr_valid, imem_if.imem_req_valid);
    end
    step();
    checks++;
    if (instr_valid !== 1'b0 || imem_if.imem_req_valid !== 1'b1 || pc_out !== 32'h0) begin
      errors++;
      $display("FAIL rsp_in_req: got iv=%b req=%b pc=%h expected 0 1 0",
               instr_valid, imem_if.imem_req_valid, pc_out);
    end
    imem_if.imem_rsp_valid = 1'b0;
  endtask

  initial begin
    reset                  = 1'b1;
    imem_if.imem_req_ready = 1'b0;
    imem_if.imem_rsp_valid = 1'b0;
    branch_target          = '0;
    jump_target            = '0;
    clear_redirects();
    test_reset();
    test_ready_delay();
    test_priority();
    test_misalign();
    test_halt();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
